// File: rtl/muxn_pkg.sv
// Shared types and defaults for the muxn_stream registered N-to-1 stream multiplexer.
package muxn_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NUM   = 4;

endpackage : muxn_pkg

// File: rtl/muxn_stream_rr_pick.sv
// rr_pick: combinational round-robin picker, first valid channel at or after ptr (with wrap).
// Only built when MUXN_STREAM_RR_EN is defined; otherwise this file is empty.
`ifdef MUXN_STREAM_RR_EN
module rr_pick #(
  parameter int P_NUM   = 4,
  parameter int P_SEL_W = $clog2(P_NUM)
) (
  input  logic [P_NUM-1:0]   valid,
  input  logic [P_SEL_W-1:0] ptr,
  output logic               grant,
  output logic [P_SEL_W-1:0] idx
);

  localparam logic [P_SEL_W:0] NUM_W = (P_SEL_W+1)'(P_NUM);

  logic [P_NUM-1:0][P_SEL_W-1:0] scan_idx;
  logic [P_NUM-1:0]              scan_hit;

  // Scan slot gi looks at channel (ptr + gi) mod P_NUM; ptr is always < P_NUM.
  for (genvar gi = 0; gi < P_NUM; gi++) begin : g_scan
    logic [P_SEL_W:0] sum;
    assign sum           = {1'b0, ptr} + (P_SEL_W+1)'(gi);
    assign scan_idx[gi]  = (sum >= NUM_W) ? P_SEL_W'(sum - NUM_W) : sum[P_SEL_W-1:0];
    assign scan_hit[gi]  = |(valid & (P_NUM'(1) << scan_idx[gi]));
  end

  // Walk from the far end so the lowest scan offset wins.
  always_comb begin
    grant = 1'b0;
    idx   = '0;
    for (int i = P_NUM - 1; i >= 0; i--) begin
      if (scan_hit[i]) begin
        grant = 1'b1;
        idx   = scan_idx[i];
      end
    end
  end

endmodule : rr_pick
`endif

// File: rtl/muxn_stream.sv
// muxn_stream: N-to-1 registered stream mux with valid/ready handshakes and a single output register.
// Define MUXN_STREAM_RR_EN to add round-robin mode (i_mode=1); otherwise select mode always applies.
module muxn_stream
  import muxn_pkg::*;
#(
  parameter int P_WIDTH = DEF_WIDTH,
  parameter int P_NUM   = DEF_NUM,
  parameter int P_SEL_W = $clog2(P_NUM)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [P_NUM-1:0][P_WIDTH-1:0] i_d,
  input  logic [P_NUM-1:0]              i_valid,
  output logic [P_NUM-1:0]              o_ready,
  input  logic                          i_mode,
  input  logic [P_SEL_W-1:0]            i_sel,
  output logic [P_WIDTH-1:0]            o_y,
  output logic [P_SEL_W-1:0]            o_src,
  output logic                          o_valid,
  input  logic                          i_ready
);

  localparam logic [P_SEL_W:0] NUM_W = (P_SEL_W+1)'(P_NUM);

  logic [P_WIDTH-1:0] y_reg, y_next, d_sel;
  logic [P_SEL_W-1:0] src_reg, src_next;
  logic               valid_reg, valid_next;
  logic               load_en, sel_grant, grant, xfer_in;
  logic [P_SEL_W-1:0] cand;

  assign load_en   = !valid_reg || i_ready;
  assign sel_grant = ({1'b0, i_sel} < NUM_W);

`ifdef MUXN_STREAM_RR_EN
  localparam logic [P_SEL_W-1:0] LAST_IDX = P_SEL_W'(P_NUM - 1);

  logic [P_SEL_W-1:0] rr_ptr_reg, rr_ptr_next, rr_idx;
  logic               rr_grant;
  mode_e              mode;

  assign mode = mode_e'(i_mode);

  rr_pick #(
    .P_NUM   (P_NUM),
    .P_SEL_W (P_SEL_W)
  ) u_rr_pick (
    .valid (i_valid),
    .ptr   (rr_ptr_reg),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  always_comb begin
    if (mode == MODE_RR) begin
      grant = rr_grant;
      cand  = rr_idx;
    end else begin
      grant = sel_grant;
      cand  = i_sel;
    end
  end

  // Pointer only advances past a channel that actually delivered a word.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (xfer_in && (mode == MODE_RR)) begin
      rr_ptr_next = (cand == LAST_IDX) ? '0 : cand + P_SEL_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = i_mode;
  assign grant       = sel_grant;
  assign cand        = i_sel;
`endif

  // Ready is one-hot on the candidate, independent of that channel's valid.
  for (genvar gi = 0; gi < P_NUM; gi++) begin : g_ready
    assign o_ready[gi] = load_en && grant && (cand == P_SEL_W'(gi));
  end

  assign xfer_in = |(o_ready & i_valid);

  // AND-OR mux keyed on o_ready avoids indexing i_d with an out-of-range select.
  always_comb begin
    d_sel = '0;
    for (int i = 0; i < P_NUM; i++) begin
      if (o_ready[i]) begin
        d_sel = d_sel | i_d[i];
      end
    end
  end

  always_comb begin
    y_next     = y_reg;
    src_next   = src_reg;
    valid_next = valid_reg;
    if (xfer_in) begin
      y_next     = d_sel;
      src_next   = cand;
      valid_next = 1'b1;
    end else if (i_ready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      y_reg     <= '0;
      src_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      y_reg     <= y_next;
      src_reg   <= src_next;
      valid_reg <= valid_next;
    end
  end

  assign o_y     = y_reg;
  assign o_src   = src_reg;
  assign o_valid = valid_reg;

endmodule : muxn_stream

// File: tb/tb_muxn_stream.sv
// Directed bench for muxn_stream: a 4x32 instance plus a 5x8 instance for out-of-range selects.
module tb_muxn_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0][31:0] d;
  logic [3:0]       valid, o_ready;
  logic             mode, ready, o_valid;
  logic [1:0]       sel, o_src;
  logic [31:0]      o_y;

  logic [4:0][7:0]  d5;
  logic [4:0]       valid5, o_ready5;
  logic             mode5, ready5, o_valid5;
  logic [2:0]       sel5, o_src5;
  logic [7:0]       o_y5;

  int tests_run    = 0;
  int tests_failed = 0;

  muxn_stream #(.P_WIDTH(32), .P_NUM(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_d(d), .i_valid(valid), .o_ready(o_ready),
    .i_mode(mode), .i_sel(sel), .o_y(o_y), .o_src(o_src), .o_valid(o_valid),
    .i_ready(ready)
  );

  muxn_stream #(.P_WIDTH(8), .P_NUM(5)) dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_d(d5), .i_valid(valid5), .o_ready(o_ready5),
    .i_mode(mode5), .i_sel(sel5), .o_y(o_y5), .o_src(o_src5), .o_valid(o_valid5),
    .i_ready(ready5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; d = '0; valid = '0; mode = 1'b0; sel = '0; ready = 1'b0;
    d5 = '0; valid5 = '0; mode5 = 1'b0; sel5 = '0; ready5 = 1'b0;
    tick(); tick();
    tests_run++;
    if ({o_valid, o_src, o_y} !== 35'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got v=%b src=%0d y=%h want 0/0/0", o_valid, o_src, o_y);
    end
    #2 rst_n = 1'b1;
    sel = 2'd3; valid = 4'hF; d[3] = 32'h12345678; ready = 1'b1;
    tick();
    $display("[TB] load before reset src=%0d y=%h", o_src, o_y);
    tests_run++;
    if ({o_valid, o_src, o_y} !== {1'b1, 2'd3, 32'h12345678}) begin
      tests_failed++;
      $display("FAIL pre_reset_load: got v=%b src=%0d y=%h want 1/3/12345678", o_valid, o_src, o_y);
    end
    ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({o_valid, o_src, o_y} !== 35'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got v=%b src=%0d y=%h want 0/0/0", o_valid, o_src, o_y);
    end
    #2 rst_n = 1'b1;
    valid = '0; ready = 1'b1;
    tick();
  endtask

  task automatic test_select();
    mode = 1'b0; ready = 1'b1; valid = 4'hF; sel = 2'd2;
    d[0] = 32'h00000000; d[1] = 32'h11111111; d[2] = 32'hAAAAAAAA; d[3] = 32'h33333333;
    #1;
    tests_run++;
    if (o_ready !== 4'b0100) begin
      tests_failed++;
      $display("FAIL sel_ready: got %b want 0100", o_ready);
    end
    tick();
    $display("[TB] select src=%0d y=%h", o_src, o_y);
    tests_run++;
    if ({o_valid, o_src, o_y} !== {1'b1, 2'd2, 32'hAAAAAAAA}) begin
      tests_failed++;
      $display("FAIL sel_load: got v=%b src=%0d y=%h want 1/2/aaaaaaaa", o_valid, o_src, o_y);
    end
    // Ready is driven on the selected channel even when it is not valid.
    valid = '0; sel = 2'd1;
    #1;
    tests_run++;
    if (o_ready !== 4'b0010) begin
      tests_failed++;
      $display("FAIL sel_ready_novalid: got %b want 0010", o_ready);
    end
    tick();
    tests_run++;
    if (o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL sel_drain: got v=%b want 0", o_valid);
    end
    // Five-channel instance: selects 5..7 are out of range.
    ready5 = 1'b1; valid5 = 5'h1F; sel5 = 3'd5;
    d5[0] = 8'h10; d5[1] = 8'h11; d5[2] = 8'h12; d5[3] = 8'h13; d5[4] = 8'h5A;
    #1;
    tests_run++;
    if (o_ready5 !== 5'b00000) begin
      tests_failed++;
      $display("FAIL sel_oob_ready: got %b want 00000", o_ready5);
    end
    tick();
    tests_run++;
    if (o_valid5 !== 1'b0) begin
      tests_failed++;
      $display("FAIL sel_oob_noload: got v=%b want 0", o_valid5);
    end
    sel5 = 3'd4;
    #1;
    tests_run++;
    if (o_ready5 !== 5'b10000) begin
      tests_failed++;
      $display("FAIL sel_last_ready: got %b want 10000", o_ready5);
    end
    tick();
    $display("[TB] select5 src=%0d y=%h", o_src5, o_y5);
    tests_run++;
    if ({o_valid5, o_src5, o_y5} !== {1'b1, 3'd4, 8'h5A}) begin
      tests_failed++;
      $display("FAIL sel_last_load: got v=%b src=%0d y=%h want 1/4/5a", o_valid5, o_src5, o_y5);
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b0; sel = 2'd0; valid = 4'hF; d[0] = 32'hCAFE0000; ready = 1'b1;
    tick();
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d[0] = 32'hDEAD0000 + k; d[3] = 32'hD00D0000 + k;
      #1;
      tests_run++;
      if (o_ready !== 4'b0000) begin
        tests_failed++;
        $display("FAIL bp_ready[%0d]: got %b want 0000", k, o_ready);
      end
      tick();
      $display("[TB] stall %0d src=%0d y=%h", k, o_src, o_y);
      tests_run++;
      if ({o_valid, o_src, o_y} !== {1'b1, 2'd0, 32'hCAFE0000}) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got v=%b src=%0d y=%h want 1/0/cafe0000", k, o_valid, o_src, o_y);
      end
    end
    sel = 2'd3; d[3] = 32'hBEEF0003; ready = 1'b1;
    #1;
    tests_run++;
    if (o_ready !== 4'b1000) begin
      tests_failed++;
      $display("FAIL bp_release_ready: got %b want 1000", o_ready);
    end
    tick();
    $display("[TB] release src=%0d y=%h", o_src, o_y);
    tests_run++;
    if ({o_valid, o_src, o_y} !== {1'b1, 2'd3, 32'hBEEF0003}) begin
      tests_failed++;
      $display("FAIL bp_release_load: got v=%b src=%0d y=%h want 1/3/beef0003", o_valid, o_src, o_y);
    end
  endtask

  task automatic test_stream();
    mode = 1'b0; sel = 2'd1; valid = 4'hF; ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      d[1] = 32'h00001000 + k;
      tick();
      $display("[TB] stream word %0d src=%0d y=%h", k, o_src, o_y);
      tests_run++;
      if ({o_valid, o_src, o_y} !== {1'b1, 2'd1, 32'h00001000 + k}) begin
        tests_failed++;
        $display("FAIL stream[%0d]: got v=%b src=%0d y=%h want 1/1/%h", k, o_valid, o_src, o_y, 32'h00001000 + k);
      end
    end
  endtask

`ifdef MUXN_STREAM_RR_EN
  task automatic test_round_robin();
    logic [1:0] exp_all [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] exp_odd [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    ready = 1'b0; valid = '0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    mode = 1'b1; ready = 1'b1; valid = 4'hF;
    for (int k = 0; k < 4; k++) d[k] = 32'h000000D0 + k;
    for (int k = 0; k < 5; k++) begin
      tick();
      $display("[TB] rr all src=%0d y=%h", o_src, o_y);
      tests_run++;
      if ({o_valid, o_src, o_y} !== {1'b1, exp_all[k], 32'h000000D0 + exp_all[k]}) begin
        tests_failed++;
        $display("FAIL rr_all[%0d]: got v=%b src=%0d y=%h want src %0d", k, o_valid, o_src, o_y, exp_all[k]);
      end
    end
    valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      $display("[TB] rr odd src=%0d y=%h", o_src, o_y);
      tests_run++;
      if ({o_valid, o_src} !== {1'b1, exp_odd[k]}) begin
        tests_failed++;
        $display("FAIL rr_odd[%0d]: got v=%b src=%0d want 1/%0d", k, o_valid, o_src, exp_odd[k]);
      end
    end
    valid = 4'b0000;
    #1;
    tests_run++;
    if (o_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rr_none_ready: got %b want 0000", o_ready);
    end
    tick();
    valid = 4'b0010; d[1] = 32'h0000C001;
    tick();
    ready = 1'b0; mode = 1'b0; sel = 2'd0; valid = 4'hF;
    d[0] = 32'h0000C000; d[1] = 32'h0000FFFF;
    #1;
    tests_run++;
    if (o_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL switch_ready: got %b want 0000", o_ready);
    end
    tick();
    tests_run++;
    if ({o_valid, o_src, o_y} !== {1'b1, 2'd1, 32'h0000C001}) begin
      tests_failed++;
      $display("FAIL switch_hold: got v=%b src=%0d y=%h want 1/1/0000c001", o_valid, o_src, o_y);
    end
    ready = 1'b1;
    tick();
    $display("[TB] switch src=%0d y=%h", o_src, o_y);
    tests_run++;
    if ({o_valid, o_src, o_y} !== {1'b1, 2'd0, 32'h0000C000}) begin
      tests_failed++;
      $display("FAIL switch_sel: got v=%b src=%0d y=%h want 1/0/0000c000", o_valid, o_src, o_y);
    end
  endtask
`else
  task automatic test_mode_ignored();
    mode = 1'b1; sel = 2'd2; valid = 4'hF; ready = 1'b1; d[2] = 32'h0BAD0002;
    #1;
    tests_run++;
    if (o_ready !== 4'b0100) begin
      tests_failed++;
      $display("FAIL mode_ignored_ready: got %b want 0100", o_ready);
    end
    tick();
    $display("[TB] mode ignored src=%0d y=%h", o_src, o_y);
    tests_run++;
    if ({o_valid, o_src, o_y} !== {1'b1, 2'd2, 32'h0BAD0002}) begin
      tests_failed++;
      $display("FAIL mode_ignored_load: got v=%b src=%0d y=%h want 1/2/0bad0002", o_valid, o_src, o_y);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_select();
    test_backpressure();
    test_stream();
`ifdef MUXN_STREAM_RR_EN
    test_round_robin();
`else
    test_mode_ignored();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_muxn_stream
